// File: rtl/dsp_result_capture_if.sv
// Handshake bundle between the DSP slice issue/result path and the result
// capture block: operation issue with credit-based ready, slice result
// inputs, and the ready/valid result stream.
interface dsp_result_capture_if #(
  parameter int P_W   = 48,
  parameter int TAG_W = 4
);
  logic             issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_ready;
  logic [P_W-1:0]   p_in;
  logic             carryout_in;
  logic             res_valid;
  logic             res_ready;
  logic [P_W-1:0]   res_p;
  logic             res_cout;
  logic [TAG_W-1:0] res_tag;

  // Side that issues operations, supplies slice results and consumes the stream.
  modport master (
    output issue_valid, issue_tag, p_in, carryout_in, res_ready,
    input  issue_ready, res_valid, res_p, res_cout, res_tag
  );

  // Side that implements the capture block.
  modport slave (
    input  issue_valid, issue_tag, p_in, carryout_in, res_ready,
    output issue_ready, res_valid, res_p, res_cout, res_tag
  );
endinterface

// File: rtl/dsp_result_capture.sv
// Result capture for a DSP48A1 slice pipeline. Each accepted issue sends a
// {valid, tag} token down a shadow pipeline as deep as the slice latency;
// when a token leaves the pipeline the slice P/CARRYOUT are written into a
// small result FIFO. Issue is credit-gated so every in-flight token is
// guaranteed a free FIFO slot on arrival.
module dsp_result_capture #(
  parameter int A0REG      = 0,
  parameter int A1REG      = 1,
  parameter int B0REG      = 0,
  parameter int B1REG      = 1,
  parameter int MREG       = 1,
  parameter int PREG       = 1,
  parameter int P_W        = 48,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  dsp_result_capture_if.slave  bus,
  output logic [2:0]           inflight,
  output logic                 overflow_err
);

  localparam int A_LAT = A0REG + A1REG;
  localparam int B_LAT = B0REG + B1REG;
  localparam int L     = ((A_LAT > B_LAT) ? A_LAT : B_LAT) + MREG + PREG;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  logic             issue_fire;
  logic             wr_en;
  logic [TAG_W-1:0] wr_tag;
  logic             rd_en;
  logic             push;
  logic             full;
  logic             empty;

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             overflow_reg;

  logic [P_W-1:0]   mem_p   [FIFO_DEPTH];
  logic             mem_c   [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag [FIFO_DEPTH];

  // Credit counts use registered state only, so a pop this cycle frees a
  // slot for issue starting next cycle.
  assign bus.issue_ready = (32'(count_reg) + 32'(inflight)) < 32'(FIFO_DEPTH);
  assign issue_fire      = bus.issue_valid & bus.issue_ready & ce;

  generate
    if (L == 0) begin : g_direct
      // Combinational slice: the result is on p_in in the issue cycle itself.
      assign wr_en    = issue_fire;
      assign wr_tag   = bus.issue_tag;
      assign inflight = 3'd0;
    end else begin : g_shadow
      logic [L-1:0]     vld_reg;
      logic [TAG_W-1:0] tag_reg [L];
      logic [2:0]       inflight_reg;

      // Shadow pipeline advances in lockstep with the slice CE so a stalled
      // slice never loses or repeats a token.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_reg <= '0;
          for (int i = 0; i < L; i++) tag_reg[i] <= '0;
        end else if (ce) begin
          vld_reg[0] <= issue_fire;
          tag_reg[0] <= bus.issue_tag;
          for (int i = 1; i < L; i++) begin
            vld_reg[i] <= vld_reg[i-1];
            tag_reg[i] <= tag_reg[i-1];
          end
        end
      end

      assign wr_en  = ce & vld_reg[L-1];
      assign wr_tag = tag_reg[L-1];

      // Token count: one in per accepted issue, one out per capture.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight_reg <= 3'd0;
        else     inflight_reg <= inflight_reg + 3'(issue_fire) - 3'(wr_en);
      end

      assign inflight = inflight_reg;
    end
  endgenerate

  assign full  = (count_reg == CW'(FIFO_DEPTH));
  assign empty = (count_reg == '0);
  assign rd_en = bus.res_valid & bus.res_ready;
  // A write into a full FIFO is still accepted when the head leaves the same edge.
  assign push  = wr_en & (~full | rd_en);

  // Result storage; contents need no reset because validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_p[wr_ptr_reg]   <= bus.p_in;
      mem_c[wr_ptr_reg]   <= bus.carryout_in;
      mem_tag[wr_ptr_reg] <= wr_tag;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (wr_en & full & ~rd_en) overflow_reg <= 1'b1;
    end
  end

  // Head is shown combinationally; forced to zero while empty so the
  // outputs read as zero out of reset.
  assign bus.res_valid = ~empty;
  assign bus.res_p     = empty ? '0   : mem_p[rd_ptr_reg];
  assign bus.res_cout  = empty ? 1'b0 : mem_c[rd_ptr_reg];
  assign bus.res_tag   = empty ? '0   : mem_tag[rd_ptr_reg];
  assign overflow_err  = overflow_reg;

endmodule

// File: tb/tb_dsp_result_capture.sv
// Bench for dsp_result_capture: one instance with default latency (3) and one
// with all stages removed (latency 0), driven with shared stimulus and checked
// every cycle against a token/queue model, plus literal spot checks.
module tb_dsp_result_capture;
  localparam int P_W   = 48;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  typedef struct { int rem; logic [TAG_W-1:0] tag; } tok_t;
  typedef struct { logic [P_W-1:0] p; logic c; logic [TAG_W-1:0] tag; } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic issue_valid = 1'b0;
  logic [TAG_W-1:0] issue_tag = '0;
  logic [P_W-1:0] p_in = '0;
  logic carryout_in = 1'b0;
  logic res_ready = 1'b0;
  logic [2:0] inflight3, inflight0;
  logic ovf3, ovf0;

  int checks = 0;
  int passed = 0;

  tok_t tok3[$];
  res_t fq3[$];
  res_t fq0[$];
  bit movf3 = 0;
  bit movf0 = 0;

  dsp_result_capture_if #(.P_W(P_W), .TAG_W(TAG_W)) bus3 ();
  dsp_result_capture_if #(.P_W(P_W), .TAG_W(TAG_W)) bus0 ();

  always #5 clk = ~clk;

  assign bus3.issue_valid = issue_valid;
  assign bus3.issue_tag   = issue_tag;
  assign bus3.p_in        = p_in;
  assign bus3.carryout_in = carryout_in;
  assign bus3.res_ready   = res_ready;
  assign bus0.issue_valid = issue_valid;
  assign bus0.issue_tag   = issue_tag;
  assign bus0.p_in        = p_in;
  assign bus0.carryout_in = carryout_in;
  assign bus0.res_ready   = res_ready;

  dsp_result_capture u_l3 (
    .clk(clk), .rst(rst), .ce(ce), .bus(bus3),
    .inflight(inflight3), .overflow_err(ovf3)
  );

  dsp_result_capture #(
    .A0REG(0), .A1REG(0), .B0REG(0), .B1REG(0), .MREG(0), .PREG(0)
  ) u_l0 (
    .clk(clk), .rst(rst), .ce(ce), .bus(bus0),
    .inflight(inflight0), .overflow_err(ovf0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Result FIFO model: pop first, then the arriving capture (if any).
  task automatic fifo_step(input int k, input bit cap, input res_t r);
    res_t q[$];
    if (k == 0) q = fq3; else q = fq0;
    if (q.size() > 0 && res_ready) void'(q.pop_front());
    if (cap) begin
      if (q.size() < DEPTH) q.push_back(r);
      else if (k == 0) movf3 = 1;
      else movf0 = 1;
    end
    if (k == 0) fq3 = q; else fq0 = q;
  endtask

  // Advance both models by one clock edge using the inputs now applied.
  task automatic model_step();
    bit fire3, fire0, cap3;
    res_t r3, r0;
    tok_t nq[$];
    if (rst) begin
      tok3.delete(); fq3.delete(); fq0.delete(); movf3 = 0; movf0 = 0;
      return;
    end
    fire3 = issue_valid && ce && (fq3.size() + tok3.size() < DEPTH);
    fire0 = issue_valid && ce && (fq0.size() < DEPTH);
    cap3 = 0;
    r3 = '{p: '0, c: 1'b0, tag: '0};
    if (ce) begin
      foreach (tok3[i]) begin
        if (tok3[i].rem == 1) begin
          cap3 = 1;
          r3 = '{p: p_in, c: carryout_in, tag: tok3[i].tag};
        end else begin
          nq.push_back('{rem: tok3[i].rem - 1, tag: tok3[i].tag});
        end
      end
      if (fire3) nq.push_back('{rem: LAT, tag: issue_tag});
      tok3 = nq;
    end
    fifo_step(0, cap3, r3);
    r0 = '{p: p_in, c: carryout_in, tag: issue_tag};
    fifo_step(1, fire0, r0);
  endtask

  task automatic compare_all();
    chk("l3_res_valid", 64'(bus3.res_valid), 64'(fq3.size() > 0));
    if (fq3.size() > 0) begin
      chk("l3_res_p", 64'(bus3.res_p), 64'(fq3[0].p));
      chk("l3_res_cout", 64'(bus3.res_cout), 64'(fq3[0].c));
      chk("l3_res_tag", 64'(bus3.res_tag), 64'(fq3[0].tag));
    end
    chk("l3_issue_ready", 64'(bus3.issue_ready), 64'(fq3.size() + tok3.size() < DEPTH));
    chk("l3_inflight", 64'(inflight3), 64'(tok3.size()));
    chk("l3_overflow", 64'(ovf3), 64'(movf3));
    chk("l0_res_valid", 64'(bus0.res_valid), 64'(fq0.size() > 0));
    if (fq0.size() > 0) begin
      chk("l0_res_p", 64'(bus0.res_p), 64'(fq0[0].p));
      chk("l0_res_cout", 64'(bus0.res_cout), 64'(fq0[0].c));
      chk("l0_res_tag", 64'(bus0.res_tag), 64'(fq0[0].tag));
    end
    chk("l0_issue_ready", 64'(bus0.issue_ready), 64'(fq0.size() < DEPTH));
    chk("l0_inflight", 64'(inflight0), 64'd0);
    chk("l0_overflow", 64'(ovf0), 64'(movf0));
  endtask

  // One clock: compare at the falling edge, step the model, then land 1ns
  // after the rising edge where the next inputs are applied.
  task automatic cycle();
    @(negedge clk);
    if (!rst) compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    res_ready = 1'b1;
    repeat (n) cycle();
    res_ready = 1'b0;
  endtask

  initial begin : main
    int nt;
    bit f;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", 64'(bus3.res_valid), 64'd0);
    chk("rst_res_p", 64'(bus3.res_p), 64'd0);
    chk("rst_inflight", 64'(inflight3), 64'd0);
    chk("rst_overflow", 64'(ovf3), 64'd0);
    chk("rst_issue_ready", 64'(bus3.issue_ready), 64'd1);
    rst = 1'b0;
    ce = 1'b1;
    cycle();

    // Latency-0 instance: result visible the cycle after issue
    issue_valid = 1'b1; issue_tag = 4'd9; p_in = 48'hABC;
    cycle();
    issue_valid = 1'b0; p_in = '0;
    chk("l0_direct_valid", 64'(bus0.res_valid), 64'd1);
    chk("l0_direct_p", 64'(bus0.res_p), 64'hABC);
    chk("l0_direct_tag", 64'(bus0.res_tag), 64'd9);
    chk("l3_direct_inflight", 64'(inflight3), 64'd1);
    drain(6);

    // Latency-3 instance: issue at cycle 0, result driven in cycle 3
    issue_valid = 1'b1; issue_tag = 4'd5;
    cycle();
    issue_valid = 1'b0;
    chk("lat_inflight_c1", 64'(inflight3), 64'd1);
    cycle();
    chk("lat_inflight_c2", 64'(inflight3), 64'd1);
    cycle();
    chk("lat_inflight_c3", 64'(inflight3), 64'd1);
    chk("lat_valid_c3", 64'(bus3.res_valid), 64'd0);
    p_in = 48'h1234;
    cycle();
    p_in = '0;
    chk("lat_valid_c4", 64'(bus3.res_valid), 64'd1);
    chk("lat_p_c4", 64'(bus3.res_p), 64'h1234);
    chk("lat_tag_c4", 64'(bus3.res_tag), 64'd5);
    chk("lat_inflight_c4", 64'(inflight3), 64'd0);
    drain(3);

    // Back-to-back issue with the consumer stalled: credits run out after 4
    res_ready = 1'b0; nt = 0; issue_tag = 4'd0; issue_valid = 1'b1;
    for (int i = 0; i < 12 && nt < 8; i++) begin
      f = issue_valid && ce && (fq3.size() + tok3.size() < DEPTH);
      cycle();
      if (f) begin
        nt++;
        issue_tag = 4'(nt);
      end
    end
    issue_valid = 1'b0;
    chk("b2b_accepted", 64'(nt), 64'd4);
    chk("b2b_l3_ready_low", 64'(bus3.issue_ready), 64'd0);
    chk("b2b_l0_ready_low", 64'(bus0.issue_ready), 64'd0);
    repeat (4) cycle();
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_l3_order", 64'(bus3.res_tag), 64'(i));
      chk("b2b_l0_order", 64'(bus0.res_tag), 64'(i));
      cycle();
    end
    res_ready = 1'b0;
    chk("b2b_empty", 64'(bus3.res_valid), 64'd0);
    chk("b2b_ready_back", 64'(bus3.issue_ready), 64'd1);
    chk("b2b_no_overflow", 64'(ovf3), 64'd0);

    // Clock-enable stall with two tokens in flight
    issue_valid = 1'b1; issue_tag = 4'd10;
    cycle();
    issue_tag = 4'd11;
    cycle();
    issue_valid = 1'b0; ce = 1'b0;
    cycle();
    chk("ce_hold_1", 64'(inflight3), 64'd2);
    cycle();
    chk("ce_hold_2", 64'(inflight3), 64'd2);
    chk("ce_no_capture", 64'(bus3.res_valid), 64'd0);
    ce = 1'b1;
    cycle();
    chk("ce_nominal_slot_empty", 64'(bus3.res_valid), 64'd0);
    cycle();
    chk("ce_late_valid", 64'(bus3.res_valid), 64'd1);
    chk("ce_late_tag", 64'(bus3.res_tag), 64'd10);
    cycle();
    chk("ce_head_stable", 64'(bus3.res_tag), 64'd10);
    drain(4);
    chk("ce_drained", 64'(bus3.res_valid), 64'd0);

    // Reset with results both queued and in flight
    issue_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      issue_tag = 4'(i); p_in = 48'(i * 17);
      cycle();
    end
    issue_valid = 1'b0;
    cycle();
    chk("pre_rst_queued", 64'(bus3.res_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus3.res_valid), 64'd0);
    chk("mid_rst_p", 64'(bus3.res_p), 64'd0);
    chk("mid_rst_tag", 64'(bus3.res_tag), 64'd0);
    chk("mid_rst_cout", 64'(bus3.res_cout), 64'd0);
    chk("mid_rst_inflight", 64'(inflight3), 64'd0);
    chk("mid_rst_l0_valid", 64'(bus0.res_valid), 64'd0);
    cycle();
    rst = 1'b0;
    issue_valid = 1'b1; issue_tag = 4'd7; p_in = '0;
    cycle();
    issue_valid = 1'b0;
    cycle();
    cycle();
    p_in = 48'hFEED; carryout_in = 1'b1;
    cycle();
    p_in = '0; carryout_in = 1'b0;
    chk("post_rst_tag", 64'(bus3.res_tag), 64'd7);
    chk("post_rst_p", 64'(bus3.res_p), 64'hFEED);
    chk("post_rst_cout", 64'(bus3.res_cout), 64'd1);
    drain(4);

    // Randomized traffic: stalled consumer first, then mostly-ready consumer
    for (int i = 0; i < 3000; i++) begin
      ce          = ($urandom_range(0, 3) != 0);
      issue_valid = $urandom_range(0, 1) != 0;
      issue_tag   = TAG_W'($urandom());
      p_in        = P_W'({$urandom(), $urandom()});
      carryout_in = $urandom_range(0, 1) != 0;
      if (i < 1500) res_ready = ($urandom_range(0, 9) < 3);
      else          res_ready = ($urandom_range(0, 9) < 8);
      cycle();
    end
    issue_valid = 1'b0; ce = 1'b1;
    drain(10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
